dadda_mult_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 8x8 combinational Dadda multipliers.
- Multiplies two WIDTH-bit operands, selectable unsigned or two's-complement signed per transaction, using Dadda reduction built from the existing 5:2, full and half adder cells.
- Registers the two-row carry-save result, then registers the final carry-propagate sum.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths (filters, MAC front-ends) with backpressure.

---
 rtl/dadda_mult_pipe.sv | 241 ++++++++++++++++++++++++
 tb/tb_dadda_mult_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dadda_mult_pipe
// Description : Pipelined WIDTH x WIDTH Dadda multiplier (unsigned or
//               Baugh-Wooley signed) with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_product,
    output logic             out_signed
);

    localparam int MAXH       = 4 * WIDTH;
    localparam int POOL_W     = 2 * MAXH;
    localparam int MAX_STAGES = 24;

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("dadda_mult_pipe: WIDTH must lie in 4..32");
        end
        if (OUT_W != 2 * WIDTH) begin : g_bad_out_w
            $error("dadda_mult_pipe: OUT_W is derived and must equal 2*WIDTH");
        end
    endgenerate

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // 5:2 compressor as three chained full adders; returns {cout1, cout2, carry, sum}.
    function automatic logic [3:0] c52(input logic x1, input logic x2, input logic x3,
                                       input logic x4, input logic x5,
                                       input logic ci1, input logic ci2);
        logic [1:0] f1, f2, f3;
        f1 = fa(x1, x2, x3);
        f2 = fa(f1[0], x4, ci1);
        f3 = fa(f2[0], x5, ci2);
        return {f1[1], f2[1], f3[1], f3[0]};
    endfunction

    logic [OUT_W-1:0] row0_d, row1_d;
    logic [OUT_W-1:0] row0_q, row1_q;
    logic             sgn1_q, s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] product_q, product_d;
    logic             sgn2_q, s2_valid_q, s2_valid_d;
    logic             s1_load, s2_load;

    // Column bit-heaps are data independent, so every loop and index below
    // folds to constant wiring once unrolled.
    always_comb begin : p_reduce
        logic [MAXH-1:0]   mat [OUT_W];
        int                mh  [OUT_W];
        logic [MAXH-1:0]   nxt [OUT_W];
        int                nh  [OUT_W];
        logic [POOL_W-1:0] pool;
        logic [MAXH-1:0]   cbuf, ncbuf, outv;
        int                pn, ptr, on, cn, ncn, rem, tgt, maxh;
        logic [1:0]        r2;
        logic [3:0]        r4;
        logic              pp;

        for (int c = 0; c < OUT_W; c++) begin
            mat[c] = '0;
            mh[c]  = 0;
            nxt[c] = '0;
            nh[c]  = 0;
        end
        pool  = '0;
        cbuf  = '0;
        ncbuf = '0;
        outv  = '0;
        pn    = 0;
        ptr   = 0;
        on    = 0;
        cn    = 0;
        ncn   = 0;
        rem   = 0;
        tgt   = 2;
        maxh  = 0;
        r2    = '0;
        r4    = '0;
        pp    = 1'b0;
        row0_d = '0;
        row1_d = '0;

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = in_a[i] & in_b[j];
                if (in_signed && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                    pp = ~pp;
                end
                mat[i + j][mh[i + j]] = pp;
                mh[i + j] = mh[i + j] + 1;
            end
        end
        mat[WIDTH][mh[WIDTH]] = in_signed;
        mh[WIDTH] = mh[WIDTH] + 1;
        mat[OUT_W - 1][mh[OUT_W - 1]] = in_signed;
        mh[OUT_W - 1] = mh[OUT_W - 1] + 1;

        for (int st = 0; st < MAX_STAGES; st++) begin
            maxh = 0;
            for (int c = 0; c < OUT_W; c++) begin
                if (mh[c] > maxh) maxh = mh[c];
            end
            if (maxh > 2) begin
                // Largest Dadda height (2,3,4,6,9,...) below the current maximum.
                tgt = 2;
                for (int k = 0; k < 10; k++) begin
                    if ((tgt * 3) / 2 < maxh) tgt = (tgt * 3) / 2;
                end
                cbuf = '0;
                cn   = 0;
                for (int c = 0; c < OUT_W; c++) begin
                    pool = '0;
                    pn   = 0;
                    for (int k = 0; k < MAXH; k++) begin
                        if (k < mh[c]) begin
                            pool[pn] = mat[c][k];
                            pn = pn + 1;
                        end
                    end
                    for (int k = 0; k < MAXH; k++) begin
                        if (k < cn) begin
                            pool[pn] = cbuf[k];
                            pn = pn + 1;
                        end
                    end
                    ncbuf = '0;
                    ncn   = 0;
                    outv  = '0;
                    on    = 0;
                    ptr   = 0;
                    for (int op = 0; op < MAXH; op++) begin
                        rem = pn - ptr;
                        if (rem + on > tgt) begin
                            if (rem >= 7 && rem + on - tgt >= 6) begin
                                r4 = c52(pool[ptr], pool[ptr+1], pool[ptr+2], pool[ptr+3],
                                         pool[ptr+4], pool[ptr+5], pool[ptr+6]);
                                outv[on] = r4[0];
                                on = on + 1;
                                ncbuf[ncn]     = r4[1];
                                ncbuf[ncn + 1] = r4[2];
                                ncbuf[ncn + 2] = r4[3];
                                ncn = ncn + 3;
                                ptr = ptr + 7;
                            end else if (rem >= 3 && rem + on - tgt >= 2) begin
                                r2 = fa(pool[ptr], pool[ptr+1], pool[ptr+2]);
                                outv[on]   = r2[0];
                                on = on + 1;
                                ncbuf[ncn] = r2[1];
                                ncn = ncn + 1;
                                ptr = ptr + 3;
                            end else if (rem >= 2) begin
                                r2 = ha(pool[ptr], pool[ptr+1]);
                                outv[on]   = r2[0];
                                on = on + 1;
                                ncbuf[ncn] = r2[1];
                                ncn = ncn + 1;
                                ptr = ptr + 2;
                            end
                        end
                    end
                    for (int k = 0; k < POOL_W; k++) begin
                        if (k >= ptr && k < pn) begin
                            outv[on] = pool[k];
                            on = on + 1;
                        end
                    end
                    nxt[c] = outv;
                    nh[c]  = on;
                    // Carries out of the top column fall off: the product is modulo 2^OUT_W.
                    cbuf = ncbuf;
                    cn   = ncn;
                end
                for (int c = 0; c < OUT_W; c++) begin
                    mat[c] = nxt[c];
                    mh[c]  = nh[c];
                end
            end
        end

        for (int c = 0; c < OUT_W; c++) begin
            row0_d[c] = mat[c][0];
            row1_d[c] = mat[c][1];
        end
    end

    assign s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
    assign s1_load    = in_valid && in_ready;
    assign s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    assign s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    assign product_d  = row0_q + row1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row0_q     <= '0;
            row1_q     <= '0;
            sgn1_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            product_q  <= '0;
            sgn2_q     <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                row0_q <= row0_d;
                row1_q <= row1_d;
                sgn1_q <= in_signed;
            end
            if (s2_load) begin
                product_q <= product_d;
                sgn2_q    <= sgn1_q;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_product = product_q;
    assign out_signed  = sgn2_q;

endmodule
`default_nettype wire

// File: tb/tb_dadda_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadda_mult_pipe
// Description : Directed and streamed checks of dadda_mult_pipe (WIDTH 8 and 13).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dadda_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_signed;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_product;

    logic        v13, rdy13, s13, ov13, or13, os13;
    logic [12:0] a13, b13;
    logic [25:0] p13;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  va [8];
    logic [7:0]  vb [8];
    logic        vs [8];
    logic [15:0] ve [8];

    logic [16:0] q8  [$];
    logic [26:0] q13 [$];
    logic [16:0] e8;
    logic [26:0] e13;

    always #5 clk = ~clk;

    dadda_mult_pipe #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_signed(out_signed)
    );

    dadda_mult_pipe #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v13), .in_ready(rdy13),
        .in_a(a13), .in_b(b13), .in_signed(s13),
        .out_valid(ov13), .out_ready(or13),
        .out_product(p13), .out_signed(os13)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ae, be;
        ae = s ? {{8{a[7]}}, a} : {8'h00, a};
        be = s ? {{8{b[7]}}, b} : {8'h00, b};
        return ae * be;
    endfunction

    function automatic logic [25:0] ref13(input logic [12:0] a, input logic [12:0] b, input logic s);
        logic [25:0] ae, be;
        ae = s ? {{13{a[12]}}, a} : {13'h0, a};
        be = s ? {{13{b[12]}}, b} : {13'h0, b};
        return ae * be;
    endfunction

    task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] e);
        va[i] = a; vb[i] = b; vs[i] = s; ve[i] = e;
    endtask

    // Back-to-back stream; each result must appear exactly two cycles after issue.
    task automatic run_stream(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n + 2; i++) begin
            in_valid = (i < n);
            if (i < n) begin
                in_a = va[i]; in_b = vb[i]; in_signed = vs[i];
                check_eq("stream_in_ready", 64'(in_ready), 64'd1);
            end
            if (i >= 2) begin
                check_eq("stream_valid", 64'(out_valid), 64'd1);
                check_eq("stream_product", 64'(out_product), 64'(ve[i-2]));
                check_eq("stream_signed", 64'(out_signed), 64'(vs[i-2]));
            end else begin
                check_eq("stream_latency", 64'(out_valid), 64'd0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int idx_in, idx_out;
        logic [7:0]  ba [5];
        logic [7:0]  bb [5];
        logic [15:0] be [5];

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        v13 = 1'b0; a13 = '0; b13 = '0; s13 = 1'b0; or13 = 1'b1;
        #2;
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_out_product", 64'(out_product), 64'd0);
        check_eq("reset_out_signed", 64'(out_signed), 64'd0);
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        set_vec(0, 8'd255, 8'd255, 1'b0, 16'hFE01);
        set_vec(1, 8'd0,   8'd200, 1'b0, 16'h0000);
        set_vec(2, 8'd1,   8'd1,   1'b0, 16'h0001);
        run_stream(3);

        set_vec(0, 8'h80, 8'h80, 1'b1, 16'h4000);
        set_vec(1, 8'h80, 8'h7F, 1'b1, 16'hC080);
        set_vec(2, 8'hFF, 8'hFF, 1'b1, 16'h0001);
        set_vec(3, 8'hFF, 8'h01, 1'b1, 16'hFFFF);
        run_stream(4);

        set_vec(0, 8'hFF, 8'h02, 1'b0, 16'h01FE);
        set_vec(1, 8'hFF, 8'h02, 1'b1, 16'hFFFE);
        run_stream(2);

        // Backpressure: downstream stalls for the three cycles after the first result.
        ba = '{8'd3, 8'd9, 8'd15, 8'd100, 8'd255};
        bb = '{8'd7, 8'd9, 8'd15, 8'd2,   8'd1};
        be = '{16'h0015, 16'h0051, 16'h00E1, 16'h00C8, 16'h00FF};
        idx_in = 0; idx_out = 0; in_signed = 1'b0;
        for (int cyc = 0; cyc < 40 && idx_out < 5; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (idx_in < 5);
            in_a = (idx_in < 5) ? ba[idx_in] : 8'h00;
            in_b = (idx_in < 5) ? bb[idx_in] : 8'h00;
            #1;
            if (cyc == 2) check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (cyc >= 2 && cyc <= 4) begin
                check_eq("bp_stall_valid", 64'(out_valid), 64'd1);
                check_eq("bp_hold_product", 64'(out_product), 64'h0015);
            end
            if (out_valid && out_ready) begin
                check_eq("bp_order", 64'(out_product), 64'(be[idx_out]));
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            @(posedge clk); #1;
        end
        check_eq("bp_count", 64'(idx_out), 64'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset with two transactions in flight.
        in_valid = 1'b1; in_a = 8'd12; in_b = 8'd11; in_signed = 1'b0;
        @(posedge clk); #1;
        in_a = 8'd20; in_b = 8'd30;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("rst_pre_valid", 64'(out_valid), 64'd1);
        check_eq("rst_pre_product", 64'(out_product), 64'd132);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_product", 64'(out_product), 64'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("rst_no_stale", 64'(out_valid), 64'd0);
            check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        end

        // Randomised streaming on both widths with 50% downstream readiness.
        for (int cyc = 0; cyc < 320; cyc++) begin
            out_ready = ($urandom_range(0, 1) == 1) || (cyc >= 300);
            in_valid  = (cyc < 300) && ($urandom_range(0, 1) == 1);
            in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom_range(0, 1));
            or13 = ($urandom_range(0, 1) == 1) || (cyc >= 300);
            v13  = (cyc < 300) && ($urandom_range(0, 1) == 1);
            a13 = 13'($urandom); b13 = 13'($urandom); s13 = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                check_eq("rnd8_expected", 64'(q8.size() > 0), 64'd1);
                if (q8.size() > 0) begin
                    e8 = q8.pop_front();
                    check_eq("rnd8_result", 64'({out_signed, out_product}), 64'(e8));
                end
            end
            if (ov13 && or13) begin
                check_eq("rnd13_expected", 64'(q13.size() > 0), 64'd1);
                if (q13.size() > 0) begin
                    e13 = q13.pop_front();
                    check_eq("rnd13_result", 64'({os13, p13}), 64'(e13));
                end
            end
            if (in_valid && in_ready) q8.push_back({in_signed, ref8(in_a, in_b, in_signed)});
            if (v13 && rdy13) q13.push_back({s13, ref13(a13, b13, s13)});
            @(posedge clk); #1;
        end
        in_valid = 1'b0; v13 = 1'b0;
        check_eq("rnd8_drained", 64'(q8.size()), 64'd0);
        check_eq("rnd13_drained", 64'(q13.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
